// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with sign fix-up and a single-entry result hold stage.
module muldiv_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int unsigned CntW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MinInt = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CntW-1:0] CntLast = CntW'(XLEN - 1);

    typedef enum logic [2:0] {StIdle, StPrep, StCalc, StFix, StDone} state_e;

    state_e            state_q, state_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic              neg_a_q, neg_a_d;
    logic              neg_b_q, neg_b_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0]   res_q, res_d;

    logic              is_mul;
    logic              sign_a, sign_b;
    logic              neg_a, neg_b;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              div_zero, div_ovf, div_special;
    logic [XLEN-1:0]   special_res;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN-1:0]   div_diff;
    logic              div_ge;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix;
    logic [XLEN-1:0]   fix_res;

    // Operand signedness by opcode; MULHSU treats only rs1 as signed.
    always_comb begin
        sign_a = 1'b0;
        sign_b = 1'b0;
        case (funct3_q)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                sign_a = 1'b1;
                sign_b = 1'b1;
            end
            3'b010:  sign_a = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        is_mul = ~funct3_q[2];
        neg_a  = sign_a & a_q[XLEN-1];
        neg_b  = sign_b & b_q[XLEN-1];
        mag_a  = neg_a ? -a_q : a_q;
        mag_b  = neg_b ? -b_q : b_q;

        div_zero    = (b_q == '0);
        div_ovf     = ~funct3_q[0] & (a_q == MinInt) & (b_q == '1);
        div_special = funct3_q[2] & (div_zero | div_ovf);
        if (div_zero) begin
            special_res = funct3_q[1] ? a_q : '1;
        end else begin
            special_res = funct3_q[1] ? '0 : MinInt;
        end
    end

    // One step of shift-add multiply / restoring divide.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {hi_q, lo_q[XLEN-1]};
        div_ge    = (div_shift >= {1'b0, opnd_q});
        div_diff  = div_shift[XLEN-1:0] - opnd_q;
    end

    always_comb begin
        prod     = {hi_q, lo_q};
        prod_fix = (neg_a_q ^ neg_b_q) ? -prod : prod;
        quo_fix  = (neg_a_q ^ neg_b_q) ? -lo_q : lo_q;
        rem_fix  = neg_a_q ? -hi_q : hi_q;
        fix_res  = '0;
        case (funct3_q)
            3'b000:                 fix_res = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_res = quo_fix;
            default:                fix_res = rem_fix;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        funct3_d = funct3_q;
        a_d      = a_q;
        b_d      = b_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opnd_d   = opnd_q;
        cnt_d    = cnt_q;
        res_d    = res_q;

        case (state_q)
            StIdle: begin
                if (in_valid && !flush) begin
                    funct3_d = funct3;
                    a_d      = op_a;
                    b_d      = op_b;
                    state_d  = StPrep;
                end
            end
            StPrep: begin
                neg_a_d = neg_a;
                neg_b_d = neg_b;
                hi_d    = '0;
                cnt_d   = '0;
                lo_d    = is_mul ? mag_b : mag_a;
                opnd_d  = is_mul ? mag_a : mag_b;
                if (div_special) begin
                    res_d   = special_res;
                    state_d = StDone;
                end else begin
                    state_d = StCalc;
                end
            end
            StCalc: begin
                cnt_d = cnt_q + CntW'(1);
                if (is_mul) begin
                    hi_d = mul_sum[XLEN:1];
                    lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
                end else begin
                    hi_d = div_ge ? div_diff : div_shift[XLEN-1:0];
                    lo_d = {lo_q[XLEN-2:0], div_ge};
                end
                if (cnt_q == CntLast) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                res_d   = fix_res;
                state_d = StDone;
            end
            StDone: begin
                if (out_ready) begin
                    res_d   = '0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Abort wins over every in-flight transition.
        if (flush && state_q != StIdle) begin
            res_d   = '0;
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            funct3_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            cnt_q    <= '0;
            res_q    <= '0;
        end else begin
            state_q  <= state_d;
            funct3_q <= funct3_d;
            a_q      <= a_d;
            b_q      <= b_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opnd_q   <= opnd_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
        end
    end

    always_comb begin
        in_ready  = (state_q == StIdle);
        busy      = (state_q != StIdle);
        out_valid = (state_q == StDone);
        result    = (state_q == StDone) ? res_q : '0;
    end

endmodule
